sim_watchdog: RTL

// - Multi-channel simulation watchdog and cycle counter for test benches; successor to the single global-timeout check.
// - Provides a free-running global cycle count and global timeout.
// - Adds NUM_CHANNELS independent inactivity watchdogs, each kicked by a bench/VProc activity strobe.
// - Outputs sticky per-channel expiry flags and a single finish request for the top-level test module.
//

---
 rtl/sim_watchdog.sv | 116 +++++++++++
 1 files changed

// File: rtl/sim_watchdog.sv
// sim_watchdog: global cycle counter/timeout plus per-channel inactivity watchdogs; SIM_WATCHDOG_DISPLAY_EN enables messages and $finish
module sim_watchdog #(
    parameter int NUM_CHANNELS   = 4,
    parameter int COUNT_WIDTH    = 32,
    parameter int GLOBAL_TIMEOUT = 20000000,
    parameter int CHAN_TIMEOUT   = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] enable,
    input  logic [NUM_CHANNELS-1:0] kick,
    input  logic [NUM_CHANNELS-1:0] clear,
    output logic [COUNT_WIDTH-1:0]  cycle_count,
    output logic [NUM_CHANNELS-1:0] expired,
    output logic                    any_expired,
    output logic                    global_timeout,
    output logic                    finish_req
);
    localparam logic [1:0] S_DIS = 2'd0;
    localparam logic [1:0] S_ARM = 2'd1;
    localparam logic [1:0] S_EXP = 2'd2;
    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] GT  = COUNT_WIDTH'(GLOBAL_TIMEOUT);
    localparam logic [COUNT_WIDTH-1:0] CT  = COUNT_WIDTH'(CHAN_TIMEOUT);

    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   gt_q, gt_d, fin_q, fin_d;

    assign cycle_count    = cnt_q;
    assign global_timeout = gt_q;
    assign finish_req     = fin_q;
    assign any_expired    = |expired;

    // saturating cycle count, sticky timeout when the count reaches GLOBAL_TIMEOUT, sticky finish request
    always_comb begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + ONE;
        gt_d  = gt_q | ((GLOBAL_TIMEOUT != 0) && !(&cnt_q) && (cnt_q + ONE == GT));
        fin_d = fin_q | any_expired | gt_q;
    end

    // global state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            gt_q  <= 1'b0;
            fin_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            gt_q  <= gt_d;
            fin_q <= fin_d;
        end
    end

    genvar c;
    generate
        for (c = 0; c < NUM_CHANNELS; c++) begin : g_ch
            logic [1:0]             st_q, st_d;
            logic [COUNT_WIDTH-1:0] ic_q, ic_d;

            assign expired[c] = (st_q == S_EXP);

            // channel FSM: disable beats kick beats timeout; only clear leaves EXPIRED
            always_comb begin
                st_d = st_q;
                ic_d = '0;
                if (st_q == S_DIS) begin
                    st_d = enable[c] ? S_ARM : S_DIS;
                end else if (st_q == S_ARM) begin
                    if (!enable[c])
                        st_d = S_DIS;
                    else if (kick[c])
                        ic_d = '0;
                    else if (ic_q + ONE == CT)
                        st_d = S_EXP;
                    else
                        ic_d = ic_q + ONE;
                end else if (st_q == S_EXP) begin
                    st_d = clear[c] ? (enable[c] ? S_ARM : S_DIS) : S_EXP;
                end else begin
                    st_d = S_DIS;
                end
            end

            // channel state registers
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    st_q <= S_DIS;
                    ic_q <= '0;
                end else begin
                    st_q <= st_d;
                    ic_q <= ic_d;
                end
            end

`ifdef SIM_WATCHDOG_DISPLAY_EN
            // report each channel expiry as it happens
            always @(posedge clk) begin
                if (!reset && st_d == S_EXP && st_q != S_EXP)
                    $display("***ERROR: watchdog channel %0d expired at cycle %0d", c, cnt_d);
            end
`else
`endif
        end
    endgenerate

`ifdef SIM_WATCHDOG_DISPLAY_EN
    // report global timeout and end the simulation the edge after finish_req sets
    always @(posedge clk) begin
        if (!reset && gt_d && !gt_q)
            $display("***ERROR: simulation timed out");
        if (!reset && fin_q)
            $finish;
    end
`else
`endif
endmodule
